// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with byte-lane write masking and init sweep
module regfile_mp #(
    parameter int ADDR_SIZE = 5,
    parameter int BYTE_SIZE = 32,
    parameter int NUM_RD    = 2,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wen,
    input  logic [ADDR_SIZE-1:0]          waddr,
    input  logic [BYTE_SIZE-1:0]          wdata,
    input  logic [BYTE_SIZE/8-1:0]        wmask,
    input  logic [NUM_RD*ADDR_SIZE-1:0]   raddr,
    output logic [NUM_RD*BYTE_SIZE-1:0]   rdata,
    output logic                          ready,
    output logic [ADDR_SIZE-1:0]          clr_addr
);

    localparam int                   DEPTH     = 2 ** ADDR_SIZE;
    localparam int                   LANES     = BYTE_SIZE / 8;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_SIZE-1:0]   clr_next;
    logic                   ready_next;
    logic                   user_we;
    logic [BYTE_SIZE-1:0]   mem [DEPTH];

    // Writes to the hardwired zero entry are filtered here so the array never holds a nonzero there.
    assign user_we = (state == RUN) && wen && !(ZERO_REG && (waddr == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_next;
            ready    <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_next   = clr_addr;
        ready_next = ready;
        case (state)
            CLEAR: begin
                ready_next = 1'b0;
                if (clr_addr == LAST_ADDR) begin
                    state_next = RUN;
                    clr_next   = '0;
                    ready_next = 1'b1;
                end else begin
                    clr_next = clr_addr + ADDR_SIZE'(1);
                end
            end
            RUN: begin
                clr_next   = '0;
                ready_next = 1'b1;
            end
            default: begin
                state_next = CLEAR;
                clr_next   = '0;
                ready_next = 1'b0;
            end
        endcase
    end

    // The array has no reset; a reset edge leaves contents alone and the sweep clears them afterwards.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (user_we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wmask[i]) begin
                        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_SIZE-1:0] ra;
            logic [BYTE_SIZE-1:0] word;
            ra   = raddr[k*ADDR_SIZE +: ADDR_SIZE];
            word = mem[ra];
            if (BYPASS && user_we && (ra == waddr)) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wmask[i]) begin
                        word[8*i +: 8] = wdata[8*i +: 8];
                    end
                end
            end
            if ((state != RUN) || (ZERO_REG && (ra == '0))) begin
                word = '0;
            end
            rdata[k*BYTE_SIZE +: BYTE_SIZE] = word;
        end
    end

endmodule
